// File: rtl/debug_rx_loader.sv
// UART-fed ASCII hex loader: turns "Waa dd dd ...\n" command lines into byte writes
// for the memory image and option bytes.
module debug_rx_loader #(
  parameter int unsigned BAUD_DIV = 417,
  parameter int unsigned MAX_ADDR = 135
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic       wrEn,
  output logic [7:0] wrAddr,
  output logic [7:0] wrData,
  output logic       frameDone,
  output logic       frameErr,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(BAUD_DIV + 1);
  localparam logic [CntW-1:0] HalfDiv = CntW'(BAUD_DIV / 2);
  localparam logic [CntW-1:0] FullDiv = CntW'(BAUD_DIV);
  localparam logic [8:0] MaxAddr9 = 9'(MAX_ADDR);

  localparam logic [1:0] RIdle  = 2'd0;
  localparam logic [1:0] RStart = 2'd1;
  localparam logic [1:0] RData  = 2'd2;
  localparam logic [1:0] RStop  = 2'd3;

  localparam logic [2:0] PIdle = 3'd0;
  localparam logic [2:0] PAh   = 3'd1;
  localparam logic [2:0] PAl   = 3'd2;
  localparam logic [2:0] PDh   = 3'd3;
  localparam logic [2:0] PDl   = 3'd4;
  localparam logic [2:0] PErr  = 3'd5;

  logic            rxMetaQ, rxSyncQ, rxPrevQ;
  logic [1:0]      rStateQ, rStateD;
  logic [CntW-1:0] bitCntQ, bitCntD;
  logic [2:0]      bitIdxQ, bitIdxD;
  logic [7:0]      shiftQ, shiftD;
  logic            rxValidQ, rxValidD, rxFerrQ, rxFerrD;
  logic [7:0]      rxByteQ, rxByteD;
  logic            sampleNow;

  assign sampleNow = (bitCntQ == CntW'(1));

  always_comb begin
    rStateD  = rStateQ;
    bitCntD  = bitCntQ;
    bitIdxD  = bitIdxQ;
    shiftD   = shiftQ;
    rxByteD  = rxByteQ;
    rxValidD = 1'b0;
    rxFerrD  = 1'b0;
    case (rStateQ)
      RIdle: begin
        // Falling edge only, so a line stuck low cannot retrigger
        if (rxPrevQ && !rxSyncQ) begin
          rStateD = RStart;
          bitCntD = HalfDiv;
        end
      end
      RStart: begin
        if (!sampleNow) begin
          bitCntD = bitCntQ - 1'b1;
        end else if (rxSyncQ) begin
          rStateD = RIdle;
        end else begin
          rStateD = RData;
          bitCntD = FullDiv;
          bitIdxD = 3'd0;
        end
      end
      RData: begin
        if (!sampleNow) begin
          bitCntD = bitCntQ - 1'b1;
        end else begin
          shiftD  = {rxSyncQ, shiftQ[7:1]};
          bitCntD = FullDiv;
          bitIdxD = bitIdxQ + 3'd1;
          if (bitIdxQ == 3'd7) rStateD = RStop;
        end
      end
      RStop: begin
        if (!sampleNow) begin
          bitCntD = bitCntQ - 1'b1;
        end else begin
          rStateD = RIdle;
          if (rxSyncQ) begin
            rxValidD = 1'b1;
            rxByteD  = shiftQ;
          end else begin
            rxFerrD = 1'b1;
          end
        end
      end
      default: rStateD = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      rxMetaQ  <= 1'b1;
      rxSyncQ  <= 1'b1;
      rxPrevQ  <= 1'b1;
      rStateQ  <= RIdle;
      bitCntQ  <= '0;
      bitIdxQ  <= 3'd0;
      shiftQ   <= 8'd0;
      rxValidQ <= 1'b0;
      rxFerrQ  <= 1'b0;
      rxByteQ  <= 8'd0;
    end else begin
      rxMetaQ  <= rx;
      rxSyncQ  <= rxMetaQ;
      rxPrevQ  <= rxSyncQ;
      rStateQ  <= rStateD;
      bitCntQ  <= bitCntD;
      bitIdxQ  <= bitIdxD;
      shiftQ   <= shiftD;
      rxValidQ <= rxValidD;
      rxFerrQ  <= rxFerrD;
      rxByteQ  <= rxByteD;
    end
  end

  logic       isHex, isLf, isSep;
  logic [3:0] hexNib;

  always_comb begin
    isHex  = 1'b1;
    hexNib = 4'd0;
    if (rxByteQ >= 8'h30 && rxByteQ <= 8'h39) begin
      hexNib = rxByteQ[3:0];
    end else if ((rxByteQ >= 8'h41 && rxByteQ <= 8'h46) ||
                 (rxByteQ >= 8'h61 && rxByteQ <= 8'h66)) begin
      hexNib = rxByteQ[3:0] + 4'd9;
    end else begin
      isHex = 1'b0;
    end
  end

  assign isLf  = (rxByteQ == 8'h0A);
  assign isSep = (rxByteQ == 8'h20) || (rxByteQ == 8'h5F);

  logic [2:0] pStateQ, pStateD;
  logic [7:0] addrQ, addrD;
  logic [3:0] hiQ, hiD;
  logic       wrEnQ, wrEnD, doneQ, doneD, errQ, errD;
  logic [7:0] wrAddrQ, wrAddrD, wrDataQ, wrDataD;

  always_comb begin
    pStateD = pStateQ;
    addrD   = addrQ;
    hiD     = hiQ;
    wrEnD   = 1'b0;
    wrAddrD = wrAddrQ;
    wrDataD = wrDataQ;
    doneD   = 1'b0;
    errD    = 1'b0;
    if (rxFerrQ && pStateQ != PIdle) begin
      pStateD = PErr;
    end else if (rxValidQ && rxByteQ != 8'h0D) begin
      case (pStateQ)
        PIdle: begin
          if (rxByteQ == 8'h57 || rxByteQ == 8'h77) begin
            pStateD = PAh;
            addrD   = 8'd0;
          end
        end
        PAh, PAl, PDl: begin
          if (isHex) begin
            if (pStateQ == PAh) begin
              hiD     = hexNib;
              pStateD = PAl;
            end else if (pStateQ == PAl) begin
              addrD   = {hiQ, hexNib};
              pStateD = ({1'b0, hiQ, hexNib} > MaxAddr9) ? PErr : PDh;
            end else if ({1'b0, addrQ} <= MaxAddr9) begin
              wrEnD   = 1'b1;
              wrAddrD = addrQ;
              wrDataD = {hiQ, hexNib};
              addrD   = addrQ + 8'd1;
              pStateD = PDh;
            end else begin
              pStateD = PErr;
            end
          end else if (isLf) begin
            errD    = 1'b1;
            pStateD = PIdle;
          end else begin
            pStateD = PErr;
          end
        end
        PDh: begin
          if (isHex) begin
            hiD     = hexNib;
            pStateD = PDl;
          end else if (isLf) begin
            doneD   = 1'b1;
            pStateD = PIdle;
          end else if (!isSep) begin
            pStateD = PErr;
          end
        end
        PErr: begin
          if (isLf) begin
            errD    = 1'b1;
            pStateD = PIdle;
          end
        end
        default: pStateD = PIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pStateQ <= PIdle;
      addrQ   <= 8'd0;
      hiQ     <= 4'd0;
      wrEnQ   <= 1'b0;
      wrAddrQ <= 8'd0;
      wrDataQ <= 8'd0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      pStateQ <= pStateD;
      addrQ   <= addrD;
      hiQ     <= hiD;
      wrEnQ   <= wrEnD;
      wrAddrQ <= wrAddrD;
      wrDataQ <= wrDataD;
      doneQ   <= doneD;
      errQ    <= errD;
    end
  end

  assign wrEn      = wrEnQ;
  assign wrAddr    = wrAddrQ;
  assign wrData    = wrDataQ;
  assign frameDone = doneQ;
  assign frameErr  = errQ;
  assign busy      = (pStateQ != PIdle);

endmodule

// File: tb/tb_debug_rx_loader.sv
// Bench for debug_rx_loader: directed and random command lines checked against a
// line-scanning reference model.
module tb_debug_rx_loader;

  localparam int BaudDiv = 8;
  localparam int MaxAddr = 135;
  localparam int FerrEv  = 256;  // event code: byte sent with a bad stop bit

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx = 1'b1;
  logic       wrEn;
  logic [7:0] wrAddr, wrData;
  logic       frameDone, frameErr, busy;

  int errors = 0;
  int checks = 0;
  int evQ[$];
  int expWr[$];
  int obsWr[$];
  int expDone, expErr, obsDone, obsErr;

  debug_rx_loader #(
    .BAUD_DIV(BaudDiv),
    .MAX_ADDR(MaxAddr)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .rx       (rx),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .frameDone(frameDone),
    .frameErr (frameErr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wrEn) obsWr.push_back(int'({wrAddr, wrData}));
    if (frameDone) obsDone++;
    if (frameErr) obsErr++;
    if (frameDone || frameErr) checkVal("done_err_excl", 32'(frameDone & frameErr), 0);
  end

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_wrEn"}, 32'(wrEn), 0);
    checkVal({tag, "_wrAddr"}, 32'(wrAddr), 0);
    checkVal({tag, "_wrData"}, 32'(wrData), 0);
    checkVal({tag, "_done"}, 32'(frameDone), 0);
    checkVal({tag, "_err"}, 32'(frameErr), 0);
    checkVal({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (BaudDiv) @(negedge clk);
  endtask

  // rstAt selects a data bit during which nRst is pulsed for one clock (-1: none)
  task automatic sendChar(input logic [7:0] c, input logic stopBit, input int rstAt);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rstAt) begin
        rx = c[i];
        repeat (BaudDiv / 2) @(negedge clk);
        nRst = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        nRst = 1'b1;
        repeat (BaudDiv / 2 - 1) @(negedge clk);
      end else begin
        sendBit(c[i]);
      end
    end
    sendBit(stopBit);
    sendBit(1'b1);
    sendBit(1'b1);
  endtask

  task automatic sendEv(input int ev);
    logic [7:0] c;
    if (ev == FerrEv) begin
      c = 8'($urandom_range(255));
      sendChar(c, 1'b0, -1);
    end else begin
      c = ev[7:0];
      sendChar(c, 1'b1, -1);
    end
  endtask

  task automatic pushStr(input string s);
    for (int i = 0; i < s.len(); i++) evQ.push_back(int'(s[i]));
  endtask

  function automatic bit isHexC(input int v);
    return (v >= 48 && v <= 57) || (v >= 65 && v <= 70) || (v >= 97 && v <= 102);
  endfunction

  function automatic int hexVal(input int v);
    if (v <= 57) return v - 48;
    if (v <= 70) return v - 55;
    return v - 87;
  endfunction

  function automatic int hexChar(input int v, input bit upper);
    if (v < 10) return 48 + v;
    return (upper ? 55 : 87) + v;
  endfunction

  function automatic int junkChar();
    int v;
    do v = int'($urandom_range(126, 33)); while (v == 87 || v == 119);
    return v;
  endfunction

  // Scans one '\n'-terminated line: first W/w opens a frame, any deviation is an error
  task automatic model();
    int c[$];
    int i, n, a, hi;
    expWr.delete();
    expDone = 0;
    expErr  = 0;
    foreach (evQ[k]) if (evQ[k] != 13) c.push_back(evQ[k]);
    n = c.size();
    i = 0;
    while (i < n && c[i] != 87 && c[i] != 119) i++;
    if (i >= n) return;
    i++;
    a = 0;
    for (int k = 0; k < 2; k++) begin
      if (i >= n || !isHexC(c[i])) begin
        expErr = 1;
        return;
      end
      a = a * 16 + hexVal(c[i]);
      i++;
    end
    if (a > MaxAddr) begin
      expErr = 1;
      return;
    end
    forever begin
      while (i < n && (c[i] == 32 || c[i] == 95)) i++;
      if (i >= n) return;
      if (c[i] == 10) begin
        expDone = 1;
        return;
      end
      if (!isHexC(c[i])) begin
        expErr = 1;
        return;
      end
      hi = hexVal(c[i]);
      i++;
      if (i >= n || !isHexC(c[i]) || a > MaxAddr) begin
        expErr = 1;
        return;
      end
      expWr.push_back(a * 256 + hi * 16 + hexVal(c[i]));
      a++;
      i++;
    end
  endtask

  task automatic runLine(input string tag);
    model();
    obsWr.delete();
    obsDone = 0;
    obsErr  = 0;
    foreach (evQ[k]) begin
      sendEv(evQ[k]);
      if (k == 0 && (evQ[0] == 87 || evQ[0] == 119)) checkVal({tag, "_busyW"}, 32'(busy), 1);
    end
    repeat (2 * BaudDiv) @(negedge clk);
    checkVal({tag, "_nwr"}, obsWr.size(), expWr.size());
    for (int k = 0; k < expWr.size() && k < obsWr.size(); k++)
      checkVal({tag, "_wr"}, obsWr[k], expWr[k]);
    checkVal({tag, "_done"}, obsDone, expDone);
    checkVal({tag, "_err"}, obsErr, expErr);
    checkVal({tag, "_busy"}, 32'(busy), 0);
    evQ.delete();
  endtask

  task automatic genLine();
    int a, nb, d, sep, pos;
    evQ.delete();
    if ($urandom_range(3) == 0) evQ.push_back(junkChar());
    evQ.push_back($urandom_range(1) ? 87 : 119);
    case ($urandom_range(3))
      0, 1:    a = int'($urandom_range(135));
      2:       a = int'($urandom_range(140, 128));
      default: a = int'($urandom_range(255));
    endcase
    evQ.push_back(hexChar(a / 16, 1'($urandom_range(1))));
    evQ.push_back(hexChar(a % 16, 1'($urandom_range(1))));
    nb = int'($urandom_range(4));
    for (int b = 0; b < nb; b++) begin
      sep = int'($urandom_range(5));
      if (sep == 0) evQ.push_back(32);
      else if (sep == 1) evQ.push_back(95);
      else if (sep == 2) evQ.push_back(13);
      d = int'($urandom_range(255));
      evQ.push_back(hexChar(d / 16, 1'($urandom_range(1))));
      evQ.push_back(hexChar(d % 16, 1'($urandom_range(1))));
    end
    if ($urandom_range(5) == 0) begin
      pos = int'($urandom_range(evQ.size() - 1));
      evQ[pos] = $urandom_range(1) ? FerrEv : junkChar();
    end
    evQ.push_back(10);
  endtask

  initial begin
    nRst = 1'b0;
    rx   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    nRst = 1'b1;
    repeat (4) @(negedge clk);

    pushStr("W00A55A\n");
    runLine("basic");
    pushStr("w86_12 34 56\r\n");
    runLine("range");
    pushStr("W1G\n");
    runLine("badhex");
    pushStr("W7F\n");
    runLine("nodata");

    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BaudDiv) @(negedge clk);
    pushStr("W0000\n");
    runLine("glitch");

    pushStr("W10");
    evQ.push_back(FerrEv);
    pushStr("\n");
    runLine("ferr");

    // Abort mid-byte with a reset; the partial 'B' must never be written
    obsWr.delete();
    obsDone = 0;
    obsErr  = 0;
    pushStr("W20A");
    foreach (evQ[k]) sendEv(evQ[k]);
    evQ.delete();
    sendChar(8'h42, 1'b1, 6);
    repeat (12 * BaudDiv) @(negedge clk);
    checkVal("abort_nwr", obsWr.size(), 0);
    checkVal("abort_done", obsDone, 0);
    checkVal("abort_err", obsErr, 0);
    checkVal("abort_busy", 32'(busy), 0);
    pushStr("W20AB\n");
    runLine("resend");

    for (int n = 0; n < 20; n++) begin
      genLine();
      runLine("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
